// File: rtl/adc_spi_responder.sv
// adc_spi_responder: emulates the SPI side of a multi-lane SAR ADC so that
// adc_manager can be exercised in loopback / HIL builds.
//
// Ports
//   aclk, areset           : clock, asynchronous active-high reset
//   cnv / busy             : conversion start in, conversion-in-progress out
//   spi_sck/csn/resetn/sdi : SPI master pins (asynchronous, synchronised here)
//   spi_sdo[NUM_SDO]       : readout lanes
//   s_axis_t*              : sample source, one sample taken per conversion
//   reg_command(_valid)    : last 24-bit command frame and its update pulse
//   status                 : {overrun, reg_mode, lane_md[1:0]}
module adc_spi_responder #(
  parameter int NUM_SDO    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CNV_CYCLES = 14
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cnv,
  output logic                  busy,
  input  logic                  spi_sck,
  input  logic                  spi_csn,
  input  logic                  spi_resetn,
  input  logic                  spi_sdi,
  output logic [NUM_SDO-1:0]    spi_sdo,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [23:0]           reg_command,
  output logic                  reg_command_valid,
  output logic [3:0]            status
);
  localparam int BCW = $clog2(CNV_CYCLES + 1);
  localparam int RCW = $clog2(DATA_WIDTH + 1);

  // [0],[1] synchroniser stages, [2] previous value for edge detection
  logic [2:0] cnv_s_q, sck_s_q, csn_s_q;
  logic [1:0] rstn_s_q, sdi_s_q;

  logic                  busy_q, busy_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic                  rdy_q, rdy_d;
  logic                  act_q, act_d;
  logic [DATA_WIDTH-1:0] rdsh_q, rdsh_d;
  logic [RCW-1:0]        rcnt_q, rcnt_d;
  logic [DATA_WIDTH-1:0] smp_q, smp_d;
  logic                  ovr_q, ovr_d;
  logic                  rmode_q, rmode_d;
  logic [1:0]            lmd_q, lmd_d;
  logic [23:0]           cmdsh_q, cmdsh_d;
  logic [23:0]           rcmd_q, rcmd_d;
  logic                  rvld_q, rvld_d;

  logic cnv_rise, sck_rise, csn_fall, csn_rise, csn_lvl, rstn_lvl, fire;
  logic [2:0]     lanes;
  logic [RCW-1:0] rnext;
  logic [3:0]     grp;

  assign cnv_rise = cnv_s_q[1] & ~cnv_s_q[2];
  assign sck_rise = sck_s_q[1] & ~sck_s_q[2];
  assign csn_fall = ~csn_s_q[1] & csn_s_q[2];
  assign csn_rise = csn_s_q[1] & ~csn_s_q[2];
  assign csn_lvl  = csn_s_q[1];
  assign rstn_lvl = rstn_s_q[1];

  // A conversion starts only outside register mode, when idle and not held in device reset
  assign fire = cnv_rise & ~rmode_q & ~busy_q & rstn_lvl;

  // Lane modes wider than the physical lane count fall back to one lane
  always_comb begin
    lanes = 3'd1;
    if (lmd_q == 2'b01 && NUM_SDO >= 2)      lanes = 3'd2;
    else if (lmd_q == 2'b10 && NUM_SDO >= 4) lanes = 3'd4;
  end

  assign rnext = rcnt_q + RCW'(lanes);

  // Top lane group of the readout shifter, MSB on the highest lane
  always_comb begin
    case (lanes)
      3'd4:    grp = rdsh_q[DATA_WIDTH-1 -: 4];
      3'd2:    grp = {2'b00, rdsh_q[DATA_WIDTH-1 -: 2]};
      default: grp = {3'b000, rdsh_q[DATA_WIDTH-1]};
    endcase
  end

  always_comb begin
    busy_d  = busy_q;
    bcnt_d  = bcnt_q;
    rdy_d   = rdy_q;
    act_d   = act_q;
    rdsh_d  = rdsh_q;
    rcnt_d  = rcnt_q;
    smp_d   = smp_q;
    ovr_d   = ovr_q;
    rmode_d = rmode_q;
    lmd_d   = lmd_q;
    cmdsh_d = cmdsh_q;
    rcmd_d  = rcmd_q;
    rvld_d  = 1'b0;

    if (busy_q) begin
      bcnt_d = bcnt_q - BCW'(1);
      if (bcnt_q == BCW'(1)) begin
        busy_d = 1'b0;
        rdy_d  = 1'b1;
      end
    end

    if (fire) begin
      // No fresh sample: resend the previous one and flag the overrun
      if (s_axis_tvalid) smp_d = s_axis_tdata;
      else               ovr_d = 1'b1;
      busy_d = 1'b1;
      bcnt_d = BCW'(CNV_CYCLES);
      rdy_d  = 1'b0;
      act_d  = 1'b0;
    end else if (csn_fall && !rmode_q && rdy_q) begin
      act_d  = 1'b1;
      rdsh_d = smp_q;
      rcnt_d = '0;
    end else if (act_q && sck_rise && !csn_lvl) begin
      rdsh_d = rdsh_q << lanes;
      rcnt_d = rnext;
      if (rnext >= RCW'(DATA_WIDTH)) begin
        act_d = 1'b0;
        rdy_d = 1'b0;
      end
    end

    // Aborted readout discards the rest of the word
    if (act_q && csn_rise) begin
      act_d = 1'b0;
      rdy_d = 1'b0;
    end

    if (csn_fall)                  cmdsh_d = '0;
    else if (sck_rise && !csn_lvl) cmdsh_d = {cmdsh_q[22:0], sdi_s_q[1]};

    if (csn_rise) begin
      rcmd_d = cmdsh_q;
      rvld_d = 1'b1;
      if (cmdsh_q[23:21] == 3'b101)
        rmode_d = 1'b1;
      else if (rmode_q && cmdsh_q[23:8] == 16'h0020)
        lmd_d = cmdsh_q[7:6];
      else if (rmode_q && cmdsh_q[23:8] == 16'h0014 && cmdsh_q[0])
        rmode_d = 1'b0;
    end

    // Device reset clears the ADC state but not overrun or the sample latch
    if (!rstn_lvl) begin
      busy_d  = 1'b0;
      bcnt_d  = '0;
      rdy_d   = 1'b0;
      act_d   = 1'b0;
      rdsh_d  = '0;
      rcnt_d  = '0;
      rmode_d = 1'b0;
      lmd_d   = 2'b00;
      cmdsh_d = '0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnv_s_q  <= 3'b000;
      sck_s_q  <= 3'b000;
      csn_s_q  <= 3'b111;
      rstn_s_q <= 2'b11;
      sdi_s_q  <= 2'b00;
      busy_q   <= 1'b0;
      bcnt_q   <= '0;
      rdy_q    <= 1'b0;
      act_q    <= 1'b0;
      rdsh_q   <= '0;
      rcnt_q   <= '0;
      smp_q    <= '0;
      ovr_q    <= 1'b0;
      rmode_q  <= 1'b0;
      lmd_q    <= 2'b00;
      cmdsh_q  <= '0;
      rcmd_q   <= '0;
      rvld_q   <= 1'b0;
    end else begin
      cnv_s_q  <= {cnv_s_q[1:0], cnv};
      sck_s_q  <= {sck_s_q[1:0], spi_sck};
      csn_s_q  <= {csn_s_q[1:0], spi_csn};
      rstn_s_q <= {rstn_s_q[0], spi_resetn};
      sdi_s_q  <= {sdi_s_q[0], spi_sdi};
      busy_q   <= busy_d;
      bcnt_q   <= bcnt_d;
      rdy_q    <= rdy_d;
      act_q    <= act_d;
      rdsh_q   <= rdsh_d;
      rcnt_q   <= rcnt_d;
      smp_q    <= smp_d;
      ovr_q    <= ovr_d;
      rmode_q  <= rmode_d;
      lmd_q    <= lmd_d;
      cmdsh_q  <= cmdsh_d;
      rcmd_q   <= rcmd_d;
      rvld_q   <= rvld_d;
    end
  end

  // Handshake is taken in the same cycle the sample is latched
  assign s_axis_tready     = fire & s_axis_tvalid;
  assign busy              = busy_q;
  assign spi_sdo           = (act_q && !rmode_q) ? grp[NUM_SDO-1:0] : '0;
  assign reg_command       = rcmd_q;
  assign reg_command_valid = rvld_q;
  assign status            = {ovr_q, rmode_q, lmd_q};
endmodule

// File: tb/tb_adc_spi_responder.sv
module tb_adc_spi_responder;
  logic        aclk, areset, cnv, busy;
  logic        spi_sck, spi_csn, spi_resetn, spi_sdi;
  logic [3:0]  spi_sdo;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic [23:0] reg_command;
  logic        reg_command_valid;
  logic [3:0]  status;

  int tests = 0, fails = 0;
  int tready_cnt = 0;
  logic [3:0] seen [0:31];

  adc_spi_responder #(.NUM_SDO(4), .DATA_WIDTH(32), .CNV_CYCLES(14)) dut (
    .aclk(aclk), .areset(areset), .cnv(cnv), .busy(busy),
    .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_resetn(spi_resetn), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .reg_command(reg_command),
    .reg_command_valid(reg_command_valid), .status(status)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) if (s_axis_tready) tready_cnt <= tready_cnt + 1;

  // All stimulus edges land on aclk falling edges (multiples of 10 ns)
  task automatic spi_frame(input logic [23:0] cmd, output int lat);
    spi_csn = 1'b0; #50;
    for (int i = 23; i >= 0; i--) begin
      spi_sdi = cmd[i]; #50;
      spi_sck = 1'b1; #50;
      spi_sck = 1'b0;
    end
    spi_sdi = 1'b0; #50;
    spi_csn = 1'b1;
    lat = 0;
    while (!reg_command_valid && lat < 20) begin #10; lat++; end
    #100;
  endtask

  task automatic spi_read(input int nclk, input int L, output logic [31:0] word);
    logic [31:0] m;
    m = (32'd1 << L) - 32'd1;
    word = '0;
    spi_csn = 1'b0; #50;
    for (int k = 0; k < nclk; k++) begin
      seen[k] = spi_sdo;
      word = (word << L) | (32'(spi_sdo) & m);
      spi_sck = 1'b1; #50;
      spi_sck = 1'b0; #50;
    end
    spi_csn = 1'b1; #100;
  endtask

  // Returns cycles busy remained high after the 40 ns cnv pulse
  task automatic conv(input logic [31:0] d, input logic v, output int n);
    s_axis_tdata = d; s_axis_tvalid = v;
    cnv = 1'b1; #40;
    cnv = 1'b0;
    n = 0;
    while (busy && n < 200) begin #10; n++; end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset;
    #100;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (spi_sdo !== 4'h0) begin fails++; $display("FAIL reset_sdo got %h want 0", spi_sdo); end
    tests++; if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL reset_tready got %b want 0", s_axis_tready); end
    tests++; if (reg_command !== 24'h0 || reg_command_valid !== 1'b0) begin
      fails++; $display("FAIL reset_cmd got %h/%b want 000000/0", reg_command, reg_command_valid); end
    tests++; if (status !== 4'h0) begin fails++; $display("FAIL reset_status got %b want 0000", status); end
    areset = 1'b0; #20;
  endtask

  task automatic test_conv_1lane;
    int n; logic [31:0] w;
    s_axis_tdata = 32'h8BADF00D; s_axis_tvalid = 1'b1;
    cnv = 1'b1; #20;
    tests++; if (busy !== 1'b0 || s_axis_tready !== 1'b1) begin
      fails++; $display("FAIL conv_edge2 got busy=%b tready=%b want 0/1", busy, s_axis_tready); end
    #10;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL conv_busy_rise got %b want 1", busy); end
    cnv = 1'b0;
    n = 0;
    while (busy && n < 100) begin n++; #10; end
    s_axis_tvalid = 1'b0;
    tests++; if (n != 14) begin fails++; $display("FAIL conv_busy_len got %0d want 14", n); end
    spi_read(32, 1, w);
    tests++; if (w !== 32'h8BADF00D) begin fails++; $display("FAIL conv_1lane_word got %h want 8badf00d", w); end
    tests++; if (spi_sdo !== 4'h0 || status !== 4'h0) begin
      fails++; $display("FAIL conv_1lane_after got sdo=%h status=%b want 0/0000", spi_sdo, status); end
  endtask

  task automatic test_lane4;
    int lat, n; logic [31:0] w;
    logic [3:0] exp_n [0:7];
    exp_n = '{4'h0, 4'h0, 4'h2, 4'h3, 4'hF, 4'hF, 4'h4, 4'h2};
    spi_frame(24'hA00000, lat);
    tests++; if (lat != 3) begin fails++; $display("FAIL cmd_valid_latency got %0d want 3", lat); end
    tests++; if (status !== 4'b0100) begin fails++; $display("FAIL l4_enter got %b want 0100", status); end
    spi_frame(24'h002080, lat);
    tests++; if (status !== 4'b0110) begin fails++; $display("FAIL l4_write got %b want 0110", status); end
    spi_frame(24'h001401, lat);
    tests++; if (reg_command !== 24'h001401 || status !== 4'b0010) begin
      fails++; $display("FAIL l4_exit got cmd=%h status=%b want 001401/0010", reg_command, status); end
    conv(32'h0023FF42, 1'b1, n);
    tests++; if (n != 13) begin fails++; $display("FAIL l4_conv got %0d want 13", n); end
    spi_read(8, 4, w);
    tests++; if (w !== 32'h0023FF42) begin fails++; $display("FAIL l4_word got %h want 0023ff42", w); end
    for (int k = 0; k < 8; k++) begin
      tests++; if (seen[k] !== exp_n[k]) begin fails++; $display("FAIL l4_nibble%0d got %h want %h", k, seen[k], exp_n[k]); end
    end
    tests++; if (spi_sdo !== 4'h0) begin fails++; $display("FAIL l4_idle_sdo got %h want 0", spi_sdo); end
  endtask

  task automatic test_lane2;
    int lat, n; logic [31:0] w;
    spi_frame(24'hA00000, lat);
    spi_frame(24'h002040, lat);
    spi_frame(24'h001401, lat);
    tests++; if (status !== 4'b0001) begin fails++; $display("FAIL l2_status got %b want 0001", status); end
    conv(32'hF0F0F0F0, 1'b1, n);
    spi_read(16, 2, w);
    tests++; if (w !== 32'hF0F0F0F0) begin fails++; $display("FAIL l2_word got %h want f0f0f0f0", w); end
    tests++; if (seen[0] !== 4'h3 || seen[1] !== 4'h3 || seen[2] !== 4'h0 || seen[3] !== 4'h0) begin
      fails++; $display("FAIL l2_pairs got %h %h %h %h want 3 3 0 0", seen[0], seen[1], seen[2], seen[3]); end
  endtask

  task automatic test_overrun;
    int n, t0; logic [31:0] w;
    t0 = tready_cnt;
    conv(32'h11111111, 1'b0, n);
    tests++; if (n != 13) begin fails++; $display("FAIL ovr_conv got %0d want 13", n); end
    spi_read(16, 2, w);
    tests++; if (w !== 32'hF0F0F0F0) begin fails++; $display("FAIL ovr_word got %h want f0f0f0f0", w); end
    tests++; if (status !== 4'b1001) begin fails++; $display("FAIL ovr_status got %b want 1001", status); end
    tests++; if (tready_cnt != t0) begin fails++; $display("FAIL ovr_tready got %0d pulses want 0", tready_cnt - t0); end
  endtask

  task automatic test_abort;
    int n; logic [31:0] w;
    conv(32'h12345678, 1'b1, n);
    spi_read(5, 2, w);
    tests++; if (w !== 32'h048) begin fails++; $display("FAIL abort_part got %h want 048", w); end
    spi_read(16, 2, w);
    tests++; if (w !== 32'h0) begin fails++; $display("FAIL abort_rest got %h want 0", w); end
  endtask

  task automatic test_resetn;
    int lat;
    spi_frame(24'hA00000, lat);
    tests++; if (status !== 4'b1101) begin fails++; $display("FAIL rstn_pre got %b want 1101", status); end
    spi_resetn = 1'b0; #50;
    tests++; if (status !== 4'b1000) begin fails++; $display("FAIL rstn_status got %b want 1000", status); end
    spi_resetn = 1'b1; #50;
  endtask

  task automatic test_regmode_gating;
    int lat, t0; logic seen_busy;
    spi_frame(24'hA00000, lat);
    tests++; if (status !== 4'b1100) begin fails++; $display("FAIL gate_enter got %b want 1100", status); end
    t0 = tready_cnt; seen_busy = 1'b0;
    s_axis_tdata = 32'hDEADBEEF; s_axis_tvalid = 1'b1;
    for (int j = 0; j < 24; j++) begin
      cnv = ((j % 8) < 4); #10;
      if (busy) seen_busy = 1'b1;
    end
    cnv = 1'b0; s_axis_tvalid = 1'b0; #40;
    tests++; if (seen_busy !== 1'b0) begin fails++; $display("FAIL gate_busy got busy=1 want 0"); end
    tests++; if (tready_cnt != t0) begin fails++; $display("FAIL gate_tready got %0d pulses want 0", tready_cnt - t0); end
    spi_frame(24'h001401, lat);
    tests++; if (status !== 4'b1000) begin fails++; $display("FAIL gate_exit got %b want 1000", status); end
  endtask

  task automatic test_areset_mid;
    int lat;
    s_axis_tdata = 32'hCAFE0000; s_axis_tvalid = 1'b1;
    cnv = 1'b1; #40;
    cnv = 1'b0; s_axis_tvalid = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL arst_pre got busy=%b want 1", busy); end
    areset = 1'b1; #10;
    tests++; if (busy !== 1'b0 || status !== 4'h0 || spi_sdo !== 4'h0) begin
      fails++; $display("FAIL arst_clear got busy=%b status=%b sdo=%h want 0/0000/0", busy, status, spi_sdo); end
    areset = 1'b0; #20;
    spi_frame(24'hA00000, lat);
    tests++; if (status !== 4'b0100 || lat != 3) begin
      fails++; $display("FAIL arst_next got status=%b lat=%0d want 0100/3", status, lat); end
  endtask

  initial begin
    areset = 1'b1; cnv = 1'b0; spi_sck = 1'b0; spi_csn = 1'b1; spi_resetn = 1'b1;
    spi_sdi = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    test_reset;
    test_conv_1lane;
    test_lane4;
    test_lane2;
    test_overrun;
    test_abort;
    test_resetn;
    test_regmode_gating;
    test_areset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
